// File: rtl/pshare_predictor.sv
// Pshare branch predictor. Each branch PC selects a per-branch local history
// from the BHT. That history is XORed with the low PC bits to pick a 2-bit
// counter in the PHT. The prediction is registered one cycle after issue.
// The resolved outcome arrives on the following cycle and trains both tables.
// Table writes are forwarded to a lookup in the same cycle, so back-to-back
// branches see fully up-to-date state.
module pshare_predictor #(
    parameter int BHT_BITS  = 4,
    parameter int HIST_BITS = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [31:0]       PC,
    input  logic [31:0]       etiqueta,
    input  logic              fix_result,
    output logic              pred_valid,
    output logic              prediction,
    output logic [31:0]       nex_PC,
    output logic [CNT_W-1:0]  hits,
    output logic [CNT_W-1:0]  misses
);

    localparam int BHT_N = 1 << BHT_BITS;
    localparam int PHT_N = 1 << HIST_BITS;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // 2-bit saturating counter step toward the resolved direction
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        else    return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Statistics counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    logic [HIST_BITS-1:0] bht_q [BHT_N];
    logic [HIST_BITS-1:0] bht_d [BHT_N];
    logic [1:0]           pht_q [PHT_N];
    logic [1:0]           pht_d [PHT_N];

    logic                 pend_valid_q, pend_valid_d;
    logic [BHT_BITS-1:0]  pend_b_q, pend_b_d;
    logic [HIST_BITS-1:0] pend_p_q, pend_p_d;
    logic                 pend_taken_q, pend_taken_d;

    logic                 pred_valid_q, pred_valid_d;
    logic                 prediction_q, prediction_d;
    logic [31:0]          nex_pc_q, nex_pc_d;
    logic [CNT_W-1:0]     hits_q, hits_d;
    logic [CNT_W-1:0]     misses_q, misses_d;

    logic [BHT_BITS-1:0]  lk_b;
    logic [HIST_BITS-1:0] lk_h;
    logic [HIST_BITS-1:0] lk_p;
    logic                 lk_taken;

    // Apply the pending update first, then look up against the updated tables
    // (write-first forwarding falls out of reading the _d copies).
    always_comb begin
        bht_d        = bht_q;
        pht_d        = pht_q;
        hits_d       = hits_q;
        misses_d     = misses_q;
        pred_valid_d = valid_in;
        prediction_d = prediction_q;
        nex_pc_d     = nex_pc_q;
        pend_valid_d = valid_in;
        pend_b_d     = pend_b_q;
        pend_p_d     = pend_p_q;
        pend_taken_d = pend_taken_q;

        if (pend_valid_q) begin
            pht_d[pend_p_q] = ctr_step(pht_q[pend_p_q], fix_result);
            bht_d[pend_b_q] = {bht_q[pend_b_q][HIST_BITS-2:0], fix_result};
            if (pend_taken_q == fix_result) hits_d   = sat_inc(hits_q);
            else                            misses_d = sat_inc(misses_q);
        end

        lk_b     = PC[BHT_BITS-1:0];
        lk_h     = bht_d[lk_b];
        lk_p     = lk_h ^ PC[HIST_BITS-1:0];
        lk_taken = pht_d[lk_p][1];

        if (valid_in) begin
            prediction_d = lk_taken;
            nex_pc_d     = lk_taken ? etiqueta : PC + 32'd4;
            pend_b_d     = lk_b;
            pend_p_d     = lk_p;
            pend_taken_d = lk_taken;
        end
    end

    // State registers; reset restores the untrained tables and drops any pending branch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= '0;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
            pend_valid_q <= 1'b0;
            pend_b_q     <= '0;
            pend_p_q     <= '0;
            pend_taken_q <= 1'b0;
            pred_valid_q <= 1'b0;
            prediction_q <= 1'b0;
            nex_pc_q     <= '0;
            hits_q       <= '0;
            misses_q     <= '0;
        end else begin
            bht_q        <= bht_d;
            pht_q        <= pht_d;
            pend_valid_q <= pend_valid_d;
            pend_b_q     <= pend_b_d;
            pend_p_q     <= pend_p_d;
            pend_taken_q <= pend_taken_d;
            pred_valid_q <= pred_valid_d;
            prediction_q <= prediction_d;
            nex_pc_q     <= nex_pc_d;
            hits_q       <= hits_d;
            misses_q     <= misses_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign prediction = prediction_q;
    assign nex_PC     = nex_pc_q;
    assign hits       = hits_q;
    assign misses     = misses_q;

endmodule

// File: doc/pshare_predictor.md
Name: pshare_predictor

Overview:
- Pshare branch predictor: the DUT that the pshare stimulus bench drives.
- Each cycle it accepts a branch PC and its target (etiqueta).
- One cycle later it presents a taken/not-taken prediction and the next fetch PC.
- One cycle after issue it consumes the resolved outcome (fix_result) to train its tables, and it counts hits and misses for statistics.

Parameters:
- BHT_BITS, 4: local-history table index width (PC[BHT_BITS-1:0]); 2^BHT_BITS entries.
- HIST_BITS, 4: local history length; PHT index width; 2^HIST_BITS 2-bit counters.
- CNT_W, 16: width of hit/miss counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  PC/etiqueta valid this cycle
- PC  in  32  branch address (byte address)
- etiqueta  in  32  branch target
- fix_result  in  1  actual outcome of the branch issued the previous cycle (1 = taken)
- pred_valid  out  1  prediction/nex_PC valid
- prediction  out  1  predicted direction
- nex_PC  out  32  predicted next PC
- hits  out  CNT_W  correct predictions
- misses  out  CNT_W  wrong predictions

Behaviour:
- Reset (reset=0, async):
  - BHT entries = 0; PHT counters = 2'b01 (weakly not-taken).
  - pred_valid=0, prediction=0, nex_PC=0, hits=0, misses=0, pending slot cleared.
  - Reset asserted mid-operation discards the pending branch; no update occurs.
- Lookup (cycle t, valid_in=1):
  - b = PC[BHT_BITS-1:0]; h = BHT[b]; p = h XOR PC[HIST_BITS-1:0]; taken = PHT[p][1].
  - At the posedge ending t: prediction<=taken; nex_PC<=taken ? etiqueta : PC+4; pred_valid<=1.
  - The pending slot latches {b, p, taken}; pend_valid<=1.
- valid_in=0 at t: pred_valid<=0; prediction and nex_PC hold; pend_valid<=0.
- Update (cycle t+1, pend_valid=1):
  - fix_result is sampled for the pending branch.
  - At the posedge ending t+1: PHT[pend_p] saturates up if fix_result=1 (max 2'b11), down if 0 (min 2'b00).
  - BHT[pend_b] <= {BHT[pend_b][HIST_BITS-2:0], fix_result}.
  - If pend_taken==fix_result: hits+1, else misses+1. Both counters saturate at all-ones; no wrap.
- fix_result is ignored when pend_valid=0.
- Write-first bypass (update and new lookup in the same cycle):
  - If new b == pend_b, the lookup uses the shifted-in history.
  - If the resulting p == pend_p, the lookup uses the updated counter.
  - Back-to-back issues of the same PC must therefore behave exactly as if each update completed before the next lookup.
- Latency: prediction 1 cycle after issue. Throughput: one branch per cycle, no stalls.

Test Plan:
- Reset check:
  - Stimulus: hold reset=0 for 3 cycles with random PC and valid_in=1.
  - Required: pred_valid=0, hits=misses=0, nex_PC=0.
  - Then release reset, issue PC=0x5 with etiqueta=0x50: prediction=0, nex_PC=0x9.
- Always-taken training:
  - Stimulus: PC=0x5, etiqueta=0x50, fix_result=1, 10 back-to-back issues.
  - Required: issues 1-5 predict not-taken (PHT indices 5, 4, 6, 2, 10 all fresh).
  - Issues 6-10 predict taken with nex_PC=0x50.
  - After the final update: hits=5, misses=5, BHT[5]=4'hF.
- Alternating pattern:
  - Stimulus: PC=0x3, outcomes T,N,T,N… for 40 issues.
  - Required: the last 8 predictions all correct (history alternates 0101/1010, PHT indices 6/9 trained opposite).
- Bypass:
  - Stimulus: PC=0x5 followed immediately by PC=0x15 (same BHT index), fix_result=1.
  - Required: the second lookup uses history 0001, PHT index 0001^0101=4, with no stale read.
- Idle gap:
  - Stimulus: issue, then valid_in=0 for 2 cycles with fix_result toggling.
  - Required: exactly one update; pred_valid drops after 1 cycle; tables unchanged during the gap.
- Saturation and mid-operation reset:
  - Stimulus: CNT_W=3, 10 consecutive misses.
  - Required: misses sticks at 7.
  - Then assert reset between issue and resolve: no counter change; all state returns to reset values.
